inst_encoder_loader: RTL

//  Encodes field-level instruction requests into 32-bit instruction words in the

---
 rtl/inst_encoder_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/inst_encoder_loader.sv
// Instruction encoder and program loader.
// Turns field-level instruction requests into 32-bit decoder-format words and
// streams them into instruction memory starting at address 0. Every program is
// terminated with a halt word, including programs cut short when memory fills.
module inst_encoder_loader #(
   parameter int INST_ADDR_WIDTH    = 9,
   parameter int REGFILE_ADDR_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_kind,
   input  logic [REGFILE_ADDR_WIDTH-1:0] in_rs1,
   input  logic [REGFILE_ADDR_WIDTH-1:0] in_rs2,
   input  logic [REGFILE_ADDR_WIDTH-1:0] in_rd,
   input  logic [3:0]                    in_func,
   input  logic [15:0]                   in_imm,
   input  logic [8:0]                    in_offset,
   input  logic                          in_last,
   output logic                          imem_we,
   output logic [INST_ADDR_WIDTH-1:0]    imem_addr,
   output logic [31:0]                   imem_wdata,
   output logic [INST_ADDR_WIDTH:0]      inst_count,
   output logic                          done,
   output logic                          overflow
);

   // Last writable address; reserved for the halt word of a truncated program.
   localparam logic [INST_ADDR_WIDTH-1:0] ADDR_MAX = {INST_ADDR_WIDTH{1'b1}};

   localparam logic [2:0] KIND_ALU   = 3'd0;
   localparam logic [2:0] KIND_ADDI  = 3'd1;
   localparam logic [2:0] KIND_LOAD  = 3'd2;
   localparam logic [2:0] KIND_STORE = 3'd3;
   localparam logic [2:0] KIND_BEQ   = 3'd4;
   localparam logic [2:0] KIND_BNEQ  = 3'd5;
   localparam logic [2:0] KIND_NOP   = 3'd6;
   localparam logic [2:0] KIND_HALT  = 3'd7;

   localparam logic [5:0] OP_ALU   = 6'b100000;
   localparam logic [5:0] OP_ADDI  = 6'b100100;
   localparam logic [5:0] OP_LOAD  = 6'b100101;
   localparam logic [5:0] OP_STORE = 6'b000110;
   localparam logic [5:0] OP_BEQ   = 6'b010000;
   localparam logic [5:0] OP_BNEQ  = 6'b001000;

   localparam logic [31:0] HALT_WORD = 32'hFC000000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT,
      S_DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [INST_ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [INST_ADDR_WIDTH:0]   inst_count_q, inst_count_d;
   logic                       imem_we_q, imem_we_d;
   logic [INST_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]                imem_wdata_q, imem_wdata_d;
   logic                       done_q, done_d;
   logic                       overflow_q, overflow_d;
   logic [31:0]                enc_word;
   logic                       ready;
   logic                       accept;

   // Pack the request fields for the current kind; fields the kind does not use stay out of the word.
   always_comb begin
      enc_word = 32'h0;
      unique case (in_kind)
         KIND_ALU:   enc_word = {OP_ALU, in_rs1, in_rs2, in_rd, 7'b0, in_func};
         KIND_ADDI:  enc_word = {OP_ADDI, in_rs1, in_rs2, in_imm};
         KIND_LOAD:  enc_word = {OP_LOAD, in_rs1, in_rs2, in_imm};
         KIND_STORE: enc_word = {OP_STORE, in_rs1, in_rs2, in_imm};
         KIND_BEQ:   enc_word = {OP_BEQ, in_rs1, in_rs2, 7'b0, in_offset};
         KIND_BNEQ:  enc_word = {OP_BNEQ, in_rs1, in_rs2, 7'b0, in_offset};
         KIND_NOP:   enc_word = 32'h0;
         KIND_HALT:  enc_word = HALT_WORD;
         default:    enc_word = 32'h0;
      endcase
   end

   // Beats are only taken while loading and while a slot other than the halt slot is free.
   always_comb begin
      ready  = (state_q == S_RUN) && (next_addr_q != ADDR_MAX);
      accept = in_valid && ready;
   end

   // Next-state and registered-output logic; the write strobe is a single-cycle pulse.
   always_comb begin
      state_d      = state_q;
      next_addr_d  = next_addr_q;
      inst_count_d = inst_count_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      done_d       = done_q;
      overflow_d   = overflow_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_RUN;
               next_addr_d  = '0;
               inst_count_d = '0;
               done_d       = 1'b0;
               overflow_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (accept) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = next_addr_q;
               imem_wdata_d = enc_word;
               next_addr_d  = next_addr_q + 1'b1;
               inst_count_d = inst_count_q + 1'b1;
               if (in_last) begin
                  if (in_kind == KIND_HALT) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_HALT;
                  end
               end
            end else if (next_addr_q == ADDR_MAX) begin
               state_d    = S_HALT;
               overflow_d = 1'b1;
            end
         end
         S_HALT: begin
            imem_we_d    = 1'b1;
            imem_addr_d  = next_addr_q;
            imem_wdata_d = HALT_WORD;
            inst_count_d = inst_count_q + 1'b1;
            state_d      = S_DONE;
            done_d       = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset discards any write that was about to be issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         next_addr_q  <= '0;
         inst_count_q <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         next_addr_q  <= next_addr_d;
         inst_count_q <= inst_count_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign in_ready   = ready;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign inst_count = inst_count_q;
   assign done       = done_q;
   assign overflow   = overflow_q;

endmodule
